// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg: completion-buffer constants and scoreboard entry type
package rv32i_types_pkg;
    localparam int CB_NUM  = 16;
    localparam int CB_TAGW = $clog2(CB_NUM);
    typedef struct packed {
        logic               busy;
        logic               ready;
        logic [CB_TAGW-1:0] tag;
    } sb_entry_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/commit/flush bundle between pipeline and scoreboard
// Writeback ready ports exist only when SB_WB_TRACK_EN is defined.
interface reg_scoreboard_if
    import rv32i_types_pkg::*;
#(
    parameter int NUM = CB_NUM
);
    localparam int TAGW = $clog2(NUM);
    logic            alloc_ena;
    logic            alloc_wen;
    logic [4:0]      alloc_vd;
    logic [TAGW-1:0] alloc_tag;
    logic            commit_ena;
    logic [4:0]      commit_vd;
    logic [TAGW-1:0] commit_tag;
    logic            flush;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_use;
    logic            rs2_use;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [TAGW-1:0] rs1_tag;
    logic [TAGW-1:0] rs2_tag;
    logic            stall;
    logic [5:0]      busy_count;
`ifdef SB_WB_TRACK_EN
    logic            ready_a;
    logic            ready_mu;
    logic            ready_du;
    logic            ready_ls;
    logic [TAGW-1:0] index_a;
    logic [TAGW-1:0] index_mu;
    logic [TAGW-1:0] index_du;
    logic [TAGW-1:0] index_ls;
    logic            rs1_ready;
    logic            rs2_ready;
    modport master (
        output alloc_ena, alloc_wen, alloc_vd, alloc_tag, commit_ena, commit_vd, commit_tag,
               flush, rs1, rs2, rs1_use, rs2_use, ready_a, ready_mu, ready_du, ready_ls,
               index_a, index_mu, index_du, index_ls,
        input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, stall, busy_count, rs1_ready, rs2_ready
    );
    modport slave (
        input  alloc_ena, alloc_wen, alloc_vd, alloc_tag, commit_ena, commit_vd, commit_tag,
               flush, rs1, rs2, rs1_use, rs2_use, ready_a, ready_mu, ready_du, ready_ls,
               index_a, index_mu, index_du, index_ls,
        output rs1_busy, rs2_busy, rs1_tag, rs2_tag, stall, busy_count, rs1_ready, rs2_ready
    );
`else
    modport master (
        output alloc_ena, alloc_wen, alloc_vd, alloc_tag, commit_ena, commit_vd, commit_tag,
               flush, rs1, rs2, rs1_use, rs2_use,
        input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, stall, busy_count
    );
    modport slave (
        input  alloc_ena, alloc_wen, alloc_vd, alloc_tag, commit_ena, commit_vd, commit_tag,
               flush, rs1, rs2, rs1_use, rs2_use,
        output rs1_busy, rs2_busy, rs1_tag, rs2_tag, stall, busy_count
    );
`endif
endinterface

// File: rtl/sb_wb_match.sv
// sb_wb_match: flags every busy register whose producer tag matches one writeback port
module sb_wb_match #(
    parameter int TAGW = 4
) (
    input  logic                 i_ready,
    input  logic [TAGW-1:0]      i_index,
    input  logic [31:0]          i_busy,
    input  logic [31:0][TAGW-1:0] i_tag,
    output logic [31:0]          o_hit
);
    for (genvar g = 0; g < 32; g++) begin : g_hit
        assign o_hit[g] = i_ready & i_busy[g] & (i_tag[g] == i_index);
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy/tag tracking against completion-buffer tags
// Define SB_WB_TRACK_EN to track writeback readiness so ready sources do not stall.
module reg_scoreboard
    import rv32i_types_pkg::*;
#(
    parameter int NUM = CB_NUM
) (
    input logic             CLK,
    input logic             RST,
    reg_scoreboard_if.slave sb
);
    localparam int TAGW = $clog2(NUM);
    sb_entry_t       r_sb [32];
    logic [5:0]      r_count;
    logic            w_alloc;
    logic            w_commit;
    logic            w_set_new;
    logic [31:0]     w_hit;
    logic [TAGW-1:0] w_rs1_tag;
    logic [TAGW-1:0] w_rs2_tag;
    always_comb begin
        w_alloc   = sb.alloc_ena & sb.alloc_wen & (sb.alloc_vd != 5'd0) & !sb.flush;
        w_commit  = sb.commit_ena & !sb.flush & r_sb[sb.commit_vd].busy &
                    (r_sb[sb.commit_vd].tag == sb.commit_tag) &
                    !(w_alloc & (sb.alloc_vd == sb.commit_vd));
        w_set_new = w_alloc & !r_sb[sb.alloc_vd].busy;
    end
`ifdef SB_WB_TRACK_EN
    logic [31:0]           w_busy;
    logic [31:0][TAGW-1:0] w_tag;
    logic [3:0][31:0]      w_hit_p;
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_busy[i] = r_sb[i].busy;
            w_tag[i]  = r_sb[i].tag;
        end
    end
    sb_wb_match #(.TAGW(TAGW)) u_match_a  (.i_ready(sb.ready_a),  .i_index(sb.index_a),  .i_busy(w_busy), .i_tag(w_tag), .o_hit(w_hit_p[0]));
    sb_wb_match #(.TAGW(TAGW)) u_match_mu (.i_ready(sb.ready_mu), .i_index(sb.index_mu), .i_busy(w_busy), .i_tag(w_tag), .o_hit(w_hit_p[1]));
    sb_wb_match #(.TAGW(TAGW)) u_match_du (.i_ready(sb.ready_du), .i_index(sb.index_du), .i_busy(w_busy), .i_tag(w_tag), .o_hit(w_hit_p[2]));
    sb_wb_match #(.TAGW(TAGW)) u_match_ls (.i_ready(sb.ready_ls), .i_index(sb.index_ls), .i_busy(w_busy), .i_tag(w_tag), .o_hit(w_hit_p[3]));
    assign w_hit        = w_hit_p[0] | w_hit_p[1] | w_hit_p[2] | w_hit_p[3];
    assign sb.rs1_ready = r_sb[sb.rs1].ready;
    assign sb.rs2_ready = r_sb[sb.rs2].ready;
`else
    assign w_hit = '0;
`endif
    // Allocation overrides a same-cycle commit or writeback on its register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) r_sb[i] <= '0;
            r_count <= '0;
        end else if (sb.flush) begin
            for (int i = 0; i < 32; i++) begin
                r_sb[i].busy  <= 1'b0;
                r_sb[i].ready <= 1'b0;
            end
            r_count <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_alloc && sb.alloc_vd == 5'(i)) begin
                    r_sb[i] <= '{busy: 1'b1, ready: 1'b0, tag: sb.alloc_tag};
                end else begin
                    if (w_commit && sb.commit_vd == 5'(i)) r_sb[i].busy <= 1'b0;
                    if (w_hit[i]) r_sb[i].ready <= 1'b1;
                end
            end
            r_count <= r_count + 6'(w_set_new) - 6'(w_commit);
        end
    end
    assign w_rs1_tag     = r_sb[sb.rs1].tag;
    assign w_rs2_tag     = r_sb[sb.rs2].tag;
    assign sb.rs1_busy   = r_sb[sb.rs1].busy;
    assign sb.rs2_busy   = r_sb[sb.rs2].busy;
    assign sb.rs1_tag    = w_rs1_tag;
    assign sb.rs2_tag    = w_rs2_tag;
    assign sb.busy_count = r_count;
    assign sb.stall      = (sb.rs1_use & r_sb[sb.rs1].busy & !r_sb[sb.rs1].ready) |
                           (sb.rs2_use & r_sb[sb.rs2].busy & !r_sb[sb.rs2].ready);
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and randomized checks of reg_scoreboard against a behavioural model
module tb_reg_scoreboard;
    localparam int TAGW = 4;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_on = 1'b0;
    bit   m_busy [32];
    int   m_tag [32];
    bit   m_ready [32];

    always #5 clk = ~clk;

    reg_scoreboard_if #(.NUM(16)) sb_if ();
    reg_scoreboard #(.NUM(16)) dut (.CLK(clk), .RST(rst), .sb(sb_if.slave));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_busy[r] = 0; m_tag[r] = 0; m_ready[r] = 0;
        end
    endtask

    function automatic bit wb_hit(input int tag);
`ifdef SB_WB_TRACK_EN
        return (sb_if.ready_a  && int'(sb_if.index_a)  == tag) ||
               (sb_if.ready_mu && int'(sb_if.index_mu) == tag) ||
               (sb_if.ready_du && int'(sb_if.index_du) == tag) ||
               (sb_if.ready_ls && int'(sb_if.index_ls) == tag);
`else
        return tag < 0;
`endif
    endfunction

    // Next-state of the register file from the inputs present at this edge.
    task automatic model_update();
        int cvd, avd;
        if (rst) begin
            model_clear();
        end else if (sb_if.flush) begin
            for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_ready[r] = 0; end
        end else begin
            for (int r = 1; r < 32; r++) if (m_busy[r] && wb_hit(m_tag[r])) m_ready[r] = 1;
            cvd = int'(sb_if.commit_vd);
            if (sb_if.commit_ena && m_busy[cvd] && m_tag[cvd] == int'(sb_if.commit_tag)) m_busy[cvd] = 0;
            avd = int'(sb_if.alloc_vd);
            if (sb_if.alloc_ena && sb_if.alloc_wen && avd != 0) begin
                m_busy[avd] = 1; m_tag[avd] = int'(sb_if.alloc_tag); m_ready[avd] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        sb_if.alloc_ena = 0; sb_if.alloc_wen = 0; sb_if.alloc_vd = 0; sb_if.alloc_tag = 0;
        sb_if.commit_ena = 0; sb_if.commit_vd = 0; sb_if.commit_tag = 0; sb_if.flush = 0;
        sb_if.rs1 = 0; sb_if.rs2 = 0; sb_if.rs1_use = 0; sb_if.rs2_use = 0;
`ifdef SB_WB_TRACK_EN
        sb_if.ready_a = 0; sb_if.ready_mu = 0; sb_if.ready_du = 0; sb_if.ready_ls = 0;
        sb_if.index_a = 0; sb_if.index_mu = 0; sb_if.index_du = 0; sb_if.index_ls = 0;
`endif
    endtask

    task automatic do_alloc(input int vd, input int tag);
        sb_if.alloc_ena = 1; sb_if.alloc_wen = 1;
        sb_if.alloc_vd = 5'(vd); sb_if.alloc_tag = TAGW'(tag);
    endtask

    task automatic do_commit(input int vd, input int tag);
        sb_if.commit_ena = 1; sb_if.commit_vd = 5'(vd); sb_if.commit_tag = TAGW'(tag);
    endtask

    task automatic randomize_inputs();
        int cvd;
        sb_if.alloc_ena = ($urandom_range(0, 9) < 6);
        sb_if.alloc_wen = ($urandom_range(0, 9) < 8);
        sb_if.alloc_vd = 5'($urandom_range(0, 7));
        sb_if.alloc_tag = TAGW'($urandom_range(0, 15));
        cvd = $urandom_range(0, 7);
        sb_if.commit_ena = $urandom_range(0, 1);
        sb_if.commit_vd = 5'(cvd);
        sb_if.commit_tag = $urandom_range(0, 1) ? TAGW'(m_tag[cvd]) : TAGW'($urandom_range(0, 15));
        sb_if.flush = ($urandom_range(0, 19) == 0);
        sb_if.rs1 = 5'($urandom_range(0, 7));
        sb_if.rs2 = 5'($urandom_range(0, 7));
        sb_if.rs1_use = $urandom_range(0, 1);
        sb_if.rs2_use = $urandom_range(0, 1);
`ifdef SB_WB_TRACK_EN
        sb_if.ready_a  = $urandom_range(0, 1);
        sb_if.ready_mu = $urandom_range(0, 1);
        sb_if.ready_du = $urandom_range(0, 1);
        sb_if.ready_ls = $urandom_range(0, 1);
        sb_if.index_a  = TAGW'(m_tag[$urandom_range(1, 7)]);
        sb_if.index_mu = TAGW'(m_tag[$urandom_range(1, 7)]);
        sb_if.index_du = TAGW'($urandom_range(0, 15));
        sb_if.index_ls = TAGW'($urandom_range(0, 15));
`endif
    endtask

    // Continuous comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        int cnt, r1, r2;
        bit rdy1, rdy2;
        if (chk_on) begin
            cnt = 0;
            for (int r = 1; r < 32; r++) cnt += int'(m_busy[r]);
            r1 = int'(sb_if.rs1);
            r2 = int'(sb_if.rs2);
            rdy1 = 0; rdy2 = 0;
`ifdef SB_WB_TRACK_EN
            rdy1 = m_ready[r1]; rdy2 = m_ready[r2];
            if (m_busy[r1]) chk("m_rs1_ready", int'(sb_if.rs1_ready), int'(rdy1));
            if (m_busy[r2]) chk("m_rs2_ready", int'(sb_if.rs2_ready), int'(rdy2));
`endif
            chk("m_busy_count", int'(sb_if.busy_count), cnt);
            chk("m_rs1_busy", int'(sb_if.rs1_busy), int'(m_busy[r1]));
            chk("m_rs2_busy", int'(sb_if.rs2_busy), int'(m_busy[r2]));
            if (m_busy[r1]) chk("m_rs1_tag", int'(sb_if.rs1_tag), m_tag[r1]);
            if (m_busy[r2]) chk("m_rs2_tag", int'(sb_if.rs2_tag), m_tag[r2]);
            chk("m_stall", int'(sb_if.stall),
                int'((sb_if.rs1_use && m_busy[r1] && !rdy1) || (sb_if.rs2_use && m_busy[r2] && !rdy2)));
        end
    end

    initial begin
        rst = 1;
        idle();
        model_clear();
        do_alloc(5, 3);
        sb_if.rs1 = 5; sb_if.rs1_use = 1;
        #1 chk_on = 1;
        repeat (3) tick();
        chk("rst_count", int'(sb_if.busy_count), 0);
        chk("rst_rs1_busy", int'(sb_if.rs1_busy), 0);
        chk("rst_stall", int'(sb_if.stall), 0);
        rst = 0;
        idle();
        // alloc then read back
        do_alloc(5, 3); tick(); idle();
        sb_if.rs1 = 5; sb_if.rs1_use = 1; #1;
        chk("a_rs1_busy", int'(sb_if.rs1_busy), 1);
        chk("a_rs1_tag", int'(sb_if.rs1_tag), 3);
        chk("a_stall", int'(sb_if.stall), 1);
        chk("a_count", int'(sb_if.busy_count), 1);
        // overwrite, stale commit, matching commit
        do_alloc(5, 7); tick(); idle();
        do_commit(5, 3); tick(); idle();
        sb_if.rs1 = 5; #1;
        chk("o_rs1_busy", int'(sb_if.rs1_busy), 1);
        chk("o_rs1_tag", int'(sb_if.rs1_tag), 7);
        chk("o_count", int'(sb_if.busy_count), 1);
        do_commit(5, 7); tick(); idle();
        sb_if.rs1 = 5; #1;
        chk("c_rs1_busy", int'(sb_if.rs1_busy), 0);
        chk("c_count", int'(sb_if.busy_count), 0);
        // same-cycle alloc and commit of one register
        do_alloc(9, 1); tick(); idle();
        do_alloc(9, 2); do_commit(9, 1); tick(); idle();
        sb_if.rs2 = 9; sb_if.rs2_use = 1; #1;
        chk("s_rs2_busy", int'(sb_if.rs2_busy), 1);
        chk("s_rs2_tag", int'(sb_if.rs2_tag), 2);
        chk("s_count", int'(sb_if.busy_count), 1);
        // flush with concurrent alloc
        for (int r = 1; r <= 4; r++) begin do_alloc(r, r); tick(); end
        idle(); #1;
        chk("f_pre_count", int'(sb_if.busy_count), 5);
        do_alloc(6, 5); do_commit(9, 2); sb_if.flush = 1; tick(); idle();
        sb_if.rs1 = 6; sb_if.rs1_use = 1; sb_if.rs2 = 1; sb_if.rs2_use = 1; #1;
        chk("f_count", int'(sb_if.busy_count), 0);
        chk("f_rs1_busy", int'(sb_if.rs1_busy), 0);
        chk("f_rs2_busy", int'(sb_if.rs2_busy), 0);
        chk("f_stall", int'(sb_if.stall), 0);
        // x0 is never busy
        do_alloc(0, 1); tick(); idle();
        sb_if.rs1 = 0; sb_if.rs1_use = 1; #1;
        chk("z_count", int'(sb_if.busy_count), 0);
        chk("z_rs1_busy", int'(sb_if.rs1_busy), 0);
        chk("z_stall", int'(sb_if.stall), 0);
`ifdef SB_WB_TRACK_EN
        do_alloc(8, 4); tick(); idle();
        sb_if.rs2 = 8; sb_if.rs2_use = 1; #1;
        chk("w_pre_stall", int'(sb_if.stall), 1);
        sb_if.ready_mu = 1; sb_if.index_mu = 4; tick(); idle();
        sb_if.rs2 = 8; sb_if.rs2_use = 1; #1;
        chk("w_rs2_busy", int'(sb_if.rs2_busy), 1);
        chk("w_rs2_ready", int'(sb_if.rs2_ready), 1);
        chk("w_stall", int'(sb_if.stall), 0);
`endif
        for (int c = 0; c < 3000; c++) begin
            tick();
            randomize_inputs();
        end
        tick();
        idle();
        // reset asserted mid-operation discards state immediately
        do_alloc(3, 6); tick(); idle();
        sb_if.rs1 = 3; sb_if.rs1_use = 1; #1;
        chk("r_pre_busy", int'(sb_if.rs1_busy), 1);
        rst = 1; model_clear(); #1;
        chk("r_rs1_busy", int'(sb_if.rs1_busy), 0);
        chk("r_count", int'(sb_if.busy_count), 0);
        chk("r_stall", int'(sb_if.stall), 0);
        tick(); tick();
        rst = 0;
        do_alloc(3, 6); tick(); idle(); tick();
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
